// File: rtl/usb_eps_pkg.sv
// Shared constants and encodings for the endpoint-status RAM arbiter.
package usb_eps_pkg;

    localparam int unsigned EPS_AW = 8;
    localparam int unsigned EPS_DW = 16;

    typedef enum logic [1:0] {
        H_IDLE = 2'b00,
        H_WAIT = 2'b01,
        H_DONE = 2'b10
    } host_st_e;

    typedef enum logic [1:0] {
        TAG_NONE = 2'b00,
        TAG_ENG  = 2'b01,
        TAG_HOST = 2'b10
    } tag_e;

endpackage

// File: rtl/usb_eps_arb_if.sv
// Engine and host-bus signal bundle for usb_eps_arb; master drives commands, slave is the arbiter.
interface usb_eps_arb_if
    import usb_eps_pkg::*;
#(
    parameter int unsigned AW = EPS_AW,
    parameter int unsigned DW = EPS_DW
);
    logic          eps_read_0;
    logic          eps_write_0;
    logic          eps_zero_0;
    logic [AW-1:0] eps_addr_0;
    logic [DW-1:0] eps_wrdata_0;
    logic [DW-1:0] eps_rddata_3;

    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic [DW-1:0] host_rdata;
    logic          host_ack;
    logic          host_busy;

    modport master (
        output eps_read_0, eps_write_0, eps_zero_0, eps_addr_0, eps_wrdata_0,
        output host_req, host_we, host_addr, host_wdata,
        input  eps_rddata_3, host_rdata, host_ack, host_busy
    );

    modport slave (
        input  eps_read_0, eps_write_0, eps_zero_0, eps_addr_0, eps_wrdata_0,
        input  host_req, host_we, host_addr, host_wdata,
        output eps_rddata_3, host_rdata, host_ack, host_busy
    );

endinterface

// File: rtl/usb_eps_ram.sv
// Endpoint-status RAM wrapper: one shared address, registered read data, write-first.
module usb_eps_ram #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 16
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= we_i ? wdata_i : mem[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/usb_eps_arb.sv
// Shares the EP status RAM between the transaction engine (fixed priority) and the host bus.
// Optional power-up clear sweep is enabled by defining USB_EPS_INIT_EN.
module usb_eps_arb
    import usb_eps_pkg::*;
#(
    parameter int unsigned AW = EPS_AW,
    parameter int unsigned DW = EPS_DW
) (
    input logic          clk,
    input logic          rst,
    usb_eps_arb_if.slave bus
);

    host_st_e      st_q, st_d;
    tag_e          tag1_q, tag1_d, tag2_q;
    logic          we_q, we_d, re_q, re_d, rd2_q;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] ram_rdata;
    logic [DW-1:0] eps_rddata_q, host_rdata_q;
    logic          host_ack_q;
    logic          eng_cmd, grant, init_busy;
    logic [AW-1:0] init_addr;

`ifdef USB_EPS_INIT_EN
    logic          init_q;
    logic [AW-1:0] init_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            init_q     <= 1'b1;
            init_cnt_q <= '0;
        end else if (init_q) begin
            init_cnt_q <= init_cnt_q + 1'b1;
            if (&init_cnt_q) begin
                init_q <= 1'b0;
            end
        end
    end

    assign init_busy = init_q;
    assign init_addr = init_cnt_q;
`else
    assign init_busy = 1'b0;
    assign init_addr = '0;
`endif

    assign eng_cmd = bus.eps_read_0 | bus.eps_write_0;
    assign grant   = (st_q == H_IDLE) & bus.host_req & ~eng_cmd & ~init_busy;

    // c0 -> c1 slot selection: sweep, then engine, then host in otherwise idle cycles.
    always_comb begin
        addr_d  = bus.eps_addr_0;
        wdata_d = bus.eps_zero_0 ? '0 : bus.eps_wrdata_0;
        we_d    = bus.eps_write_0;
        re_d    = bus.eps_read_0 & ~bus.eps_write_0;
        tag1_d  = eng_cmd ? TAG_ENG : TAG_NONE;
        if (init_busy) begin
            addr_d  = init_addr;
            wdata_d = '0;
            we_d    = 1'b1;
            re_d    = 1'b0;
            tag1_d  = TAG_NONE;
        end else if (grant) begin
            addr_d  = bus.host_addr;
            wdata_d = bus.host_wdata;
            we_d    = bus.host_we;
            re_d    = ~bus.host_we;
            tag1_d  = TAG_HOST;
        end
    end

    always_comb begin
        st_d = st_q;
        unique case (st_q)
            H_IDLE:  if (grant) st_d = H_WAIT;
            H_WAIT:  if (host_ack_q) st_d = H_DONE;
            H_DONE:  st_d = H_IDLE;
            default: st_d = H_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q         <= H_IDLE;
            tag1_q       <= TAG_NONE;
            tag2_q       <= TAG_NONE;
            we_q         <= 1'b0;
            re_q         <= 1'b0;
            rd2_q        <= 1'b0;
            host_ack_q   <= 1'b0;
            eps_rddata_q <= '0;
            host_rdata_q <= '0;
        end else begin
            st_q       <= st_d;
            tag1_q     <= tag1_d;
            tag2_q     <= tag1_q;
            we_q       <= we_d;
            re_q       <= re_d;
            rd2_q      <= re_q;
            host_ack_q <= (tag2_q == TAG_HOST);
            if (tag2_q == TAG_ENG && rd2_q) begin
                eps_rddata_q <= ram_rdata;
            end
            if (tag2_q == TAG_HOST && rd2_q) begin
                host_rdata_q <= ram_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    usb_eps_ram #(
        .AW (AW),
        .DW (DW)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (we_q),
        .re_i    (re_q),
        .addr_i  (addr_q),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    assign bus.eps_rddata_3 = eps_rddata_q;
    assign bus.host_rdata   = host_rdata_q;
    assign bus.host_ack     = host_ack_q;
    assign bus.host_busy    = (st_q != H_IDLE) | init_busy;

endmodule

// File: tb/tb_usb_eps_arb.sv
// Directed self-checking bench for usb_eps_arb; covers the clear sweep when USB_EPS_INIT_EN is set.
module tb_usb_eps_arb;
    import usb_eps_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

`ifdef USB_EPS_INIT_EN
    localparam logic INIT = 1'b1;
`else
    localparam logic INIT = 1'b0;
`endif
    // The sweep zeroes the RAM on every reset, so data written before a reset is gone.
    localparam logic [15:0] EXP40_AFTER_RST = INIT ? 16'h0000 : 16'h1234;

    always #5 clk = ~clk;

    usb_eps_arb_if bus ();

    usb_eps_arb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(posedge clk) begin
        if (!rst) begin
            assert (!(bus.eps_read_0 && bus.eps_write_0))
                else $error("engine read and write asserted together");
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.eps_read_0   = 1'b0;
        bus.eps_write_0  = 1'b0;
        bus.eps_zero_0   = 1'b0;
        bus.eps_addr_0   = '0;
        bus.eps_wrdata_0 = '0;
        bus.host_req     = 1'b0;
        bus.host_we      = 1'b0;
        bus.host_addr    = '0;
        bus.host_wdata   = '0;
    endtask

    task automatic eng_write(input logic [7:0] a, input logic [15:0] d, input logic z);
        bus.eps_write_0  = 1'b1;
        bus.eps_addr_0   = a;
        bus.eps_wrdata_0 = d;
        bus.eps_zero_0   = z;
        tick();
        bus.eps_write_0  = 1'b0;
        bus.eps_zero_0   = 1'b0;
    endtask

    task automatic eng_read(input logic [7:0] a);
        bus.eps_read_0 = 1'b1;
        bus.eps_addr_0 = a;
        tick();
        bus.eps_read_0 = 1'b0;
    endtask

    // Requests in an idle cycle; lat counts cycles from grant to ack (-1 on timeout).
    task automatic host_xfer(input logic we, input logic [7:0] a, input logic [15:0] d,
                             output logic [15:0] rd, output int lat);
        lat = -1;
        rd  = 16'hxxxx;
        bus.host_req   = 1'b1;
        bus.host_we    = we;
        bus.host_addr  = a;
        bus.host_wdata = d;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.host_ack) begin
                lat = i;
                rd  = bus.host_rdata;
                break;
            end
        end
        bus.host_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (bus.host_busy && n < 400) begin
            tick();
            n++;
        end
        n_cmp++;
        if (bus.host_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL ready_wait: host_busy=%b after %0d cycles, want 0", bus.host_busy, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
        n_cmp++;
        if (bus.eps_rddata_3 !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_eps_rddata: got %h want 0000", bus.eps_rddata_3);
        end
        n_cmp++;
        if (bus.host_rdata !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_host_rdata: got %h want 0000", bus.host_rdata);
        end
        n_cmp++;
        if (bus.host_ack !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_host_ack: got %b want 0", bus.host_ack);
        end
        n_cmp++;
        if (bus.host_busy !== INIT) begin
            n_bad++;
            $display("FAIL reset_host_busy: got %b want %b", bus.host_busy, INIT);
        end
        wait_ready();
    endtask

    task automatic test_engine_rw();
        eng_write(8'h12, 16'hA5C3, 1'b0);
        tick();
        eng_read(8'h12);
        tick();
        n_cmp++;
        if (bus.eps_rddata_3 !== 16'h0000) begin
            n_bad++;
            $display("FAIL eng_rd_early: got %h want 0000 at cycle 2", bus.eps_rddata_3);
        end
        tick();
        n_cmp++;
        if (bus.eps_rddata_3 !== 16'hA5C3) begin
            n_bad++;
            $display("FAIL eng_rd_lat3: got %h want a5c3", bus.eps_rddata_3);
        end
        tick();
        n_cmp++;
        if (bus.eps_rddata_3 !== 16'hA5C3) begin
            n_bad++;
            $display("FAIL eng_rd_hold: got %h want a5c3", bus.eps_rddata_3);
        end
    endtask

    task automatic test_zero();
        eng_write(8'h21, 16'hBEEF, 1'b1);
        eng_write(8'h22, 16'h1111, 1'b0);
        bus.eps_zero_0   = 1'b1;
        bus.eps_addr_0   = 8'h22;
        bus.eps_wrdata_0 = 16'h2222;
        tick();
        bus.eps_zero_0   = 1'b0;
        eng_read(8'h21);
        tick();
        tick();
        n_cmp++;
        if (bus.eps_rddata_3 !== 16'h0000) begin
            n_bad++;
            $display("FAIL eng_zero_write: got %h want 0000", bus.eps_rddata_3);
        end
        eng_read(8'h22);
        tick();
        tick();
        n_cmp++;
        if (bus.eps_rddata_3 !== 16'h1111) begin
            n_bad++;
            $display("FAIL eng_zero_alone: got %h want 1111", bus.eps_rddata_3);
        end
    endtask

    task automatic test_host_rw();
        logic [15:0] rd;
        int          lat;
        host_xfer(1'b1, 8'h40, 16'h1234, rd, lat);
        n_cmp++;
        if (lat !== 3) begin
            n_bad++;
            $display("FAIL host_wr_lat: got %0d want 3", lat);
        end
        n_cmp++;
        if (rd !== 16'h0000) begin
            n_bad++;
            $display("FAIL host_wr_rdata_hold: got %h want 0000", rd);
        end
        host_xfer(1'b0, 8'h40, 16'h0, rd, lat);
        n_cmp++;
        if (lat !== 3 || rd !== 16'h1234) begin
            n_bad++;
            $display("FAIL host_rd_40: got lat %0d data %h want lat 3 data 1234", lat, rd);
        end
        host_xfer(1'b0, 8'h12, 16'h0, rd, lat);
        n_cmp++;
        if (rd !== 16'hA5C3) begin
            n_bad++;
            $display("FAIL host_sees_eng: got %h want a5c3", rd);
        end
        host_xfer(1'b1, 8'h55, 16'hCAFE, rd, lat);
        eng_read(8'h55);
        tick();
        tick();
        n_cmp++;
        if (bus.eps_rddata_3 !== 16'hCAFE) begin
            n_bad++;
            $display("FAIL eng_sees_host: got %h want cafe", bus.eps_rddata_3);
        end
    endtask

    task automatic test_engine_block();
        logic [7:0]  addrs [5];
        logic [15:0] exp_d [5];
        logic [15:0] rd;
        int          ack_at;
        addrs = '{8'h12, 8'h21, 8'h22, 8'h40, 8'h55};
        exp_d = '{16'hA5C3, 16'h0000, 16'h1111, 16'h1234, 16'hCAFE};
        ack_at = -1;
        rd = 16'h0;
        bus.host_req  = 1'b1;
        bus.host_we   = 1'b0;
        bus.host_addr = 8'h40;
        for (int k = 0; k <= 10; k++) begin
            if (k < 5) begin
                bus.eps_read_0 = 1'b1;
                bus.eps_addr_0 = addrs[k];
            end else begin
                bus.eps_read_0 = 1'b0;
            end
            if (k >= 3 && k <= 7) begin
                n_cmp++;
                if (bus.eps_rddata_3 !== exp_d[k-3]) begin
                    n_bad++;
                    $display("FAIL block_eng_data[%0d]: got %h want %h",
                             k - 3, bus.eps_rddata_3, exp_d[k-3]);
                end
            end
            if (k <= 5) begin
                n_cmp++;
                if (bus.host_busy !== 1'b0) begin
                    n_bad++;
                    $display("FAIL block_no_grant: host_busy=%b at cycle %0d want 0",
                             bus.host_busy, k);
                end
            end
            if (bus.host_ack && ack_at < 0) begin
                ack_at = k;
                rd     = bus.host_rdata;
                bus.host_req = 1'b0;
            end
            tick();
        end
        bus.host_req = 1'b0;
        n_cmp++;
        if (ack_at !== 8 || rd !== 16'h1234) begin
            n_bad++;
            $display("FAIL block_ack: got ack cycle %0d data %h want cycle 8 data 1234",
                     ack_at, rd);
        end
    endtask

    task automatic test_back_to_back();
        int a1, a2;
        a1 = -1;
        a2 = -1;
        bus.host_req  = 1'b1;
        bus.host_we   = 1'b0;
        bus.host_addr = 8'h40;
        for (int i = 0; i < 30; i++) begin
            if (bus.host_ack) begin
                if (a1 < 0) a1 = i;
                else a2 = i;
            end
            if (a2 >= 0) break;
            tick();
        end
        bus.host_req = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (a1 !== 3 || a2 !== 8) begin
            n_bad++;
            $display("FAIL back_to_back: got acks at %0d,%0d want 3,8", a1, a2);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] rd;
        int          lat, acks;
        bus.host_req  = 1'b1;
        bus.host_we   = 1'b0;
        bus.host_addr = 8'h40;
        tick();
        n_cmp++;
        if (bus.host_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_busy_wait: got %b want 1", bus.host_busy);
        end
        rst = 1'b1;
        bus.host_req = 1'b0;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (bus.host_busy !== INIT || bus.host_ack !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset_state: got busy %b ack %b want busy %b ack 0",
                     bus.host_busy, bus.host_ack, INIT);
        end
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.host_ack) acks++;
        end
        n_cmp++;
        if (acks !== 0) begin
            n_bad++;
            $display("FAIL mid_no_ack: got %0d acks want 0", acks);
        end
        wait_ready();
        host_xfer(1'b0, 8'h40, 16'h0, rd, lat);
        n_cmp++;
        if (lat !== 3 || rd !== EXP40_AFTER_RST) begin
            n_bad++;
            $display("FAIL mid_rerequest: got lat %0d data %h want lat 3 data %h",
                     lat, rd, EXP40_AFTER_RST);
        end
    endtask

`ifdef USB_EPS_INIT_EN
    task automatic test_init_sweep();
        logic [15:0] rd;
        int          lat, n;
        host_xfer(1'b1, 8'hFF, 16'hFFFF, rd, lat);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n = 0;
        while (bus.host_busy && n < 400) begin
            n++;
            tick();
        end
        n_cmp++;
        if (n !== 256) begin
            n_bad++;
            $display("FAIL init_busy_len: got %0d cycles want 256", n);
        end
        host_xfer(1'b0, 8'hFF, 16'h0, rd, lat);
        n_cmp++;
        if (lat !== 3 || rd !== 16'h0000) begin
            n_bad++;
            $display("FAIL init_cleared: got lat %0d data %h want lat 3 data 0000", lat, rd);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_engine_rw();
        test_zero();
        test_host_rw();
        test_engine_block();
        test_back_to_back();
        test_reset_mid();
`ifdef USB_EPS_INIT_EN
        test_init_sweep();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/usb_eps_arb.md
Name: usb_eps_arb

Overview:
Owns the 256x16 endpoint-status RAM and shares it between two requesters: the USB transaction engine and the host bus interface.
- Engine has absolute priority, fixed 3-cycle read latency, and never stalls.
- Host accesses use a req/ack handshake and are slotted into idle cycles.
- Sits between the transaction engine, the bus register block and the EP status RAM macro.

Parameters:
AW, 8, RAM address width (256 entries)
DW, 16, RAM data width

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; synchronous, active-high
eps_read_0  in  1  engine read command, cycle 0
eps_write_0  in  1  engine write command, cycle 0
eps_zero_0  in  1  engine: force write data to 0 (qualifies eps_write_0)
eps_addr_0  in  AW  engine address
eps_wrdata_0  in  DW  engine write data
eps_rddata_3  out  DW  engine read data, valid 3 cycles after eps_read_0
host_req  in  1  host request; held until host_ack
host_we  in  1  host write (1) / read (0)
host_addr  in  AW  host address
host_wdata  in  DW  host write data
host_rdata  out  DW  host read data, valid with host_ack
host_ack  out  1  one-cycle completion pulse
host_busy  out  1  host op granted, awaiting ack

Behaviour:
- Pipeline:
  - c0: engine command sampled.
  - c1: registered RAM address/wdata/we/re.
  - c2: RAM output.
  - c3: eps_rddata_3 register.
  - eps_rddata_3 updates only on cycles with a valid engine read tag at c3; otherwise it holds.
- Engine rules:
  - eps_read_0 and eps_write_0 are mutually exclusive.
  - Both high: write wins; a bench assertion flags it.
  - eps_zero_0 with eps_write_0 writes 16'h0000.
  - eps_zero_0 alone is ignored.
- Host FSM:
  - H_IDLE:
    - host_req & no engine cmd at c0 -> grant. The host op enters the c1 slot and the FSM moves to H_WAIT.
    - Engine cmd present -> stay; the host retries every cycle, with no starvation bound.
  - H_WAIT: a tag travels c1->c3. At c3, host_rdata is loaded (reads only), host_ack pulses and the FSM moves to H_DONE.
  - H_DONE: one cycle, ignores host_req, then returns to H_IDLE.
    - A host holding req high after ack therefore starts a new transaction no earlier than 2 cycles later.
- Host write ack latency: 3 cycles after grant, same as reads, so ordering is uniform.
- Minimum host op is 3 cycles from grant to ack.
- Read-after-write: a write at c1 followed by a read of the same address at c1 of the next cycle returns the new data (RAM write-first). Engine write followed by a host read of the same address observes the engine data.
- Only one host op is in flight.
- Reset, all outputs: eps_rddata_3=0, host_rdata=0, host_ack=0, host_busy=0.
  - FSM goes to H_IDLE and pipeline tags clear.
  - RAM contents are not altered unless USB_EPS_INIT_EN is set.
  - Reset mid-op drops the host op with no ack; the host must re-request.
- host_busy = (FSM != H_IDLE).

Optional Feature:
USB_EPS_INIT_EN
- Defined:
  - After rst, an 8-bit sweep counter writes 0 to all 256 entries, one per cycle, through the c1 slot.
  - Engine commands during the sweep are dropped (the engine is held off by the USB core reset in practice).
  - host_busy=1 and host_req is ignored until the sweep completes, i.e. 256 cycles after rst deasserts.
- Undefined: no sweep; RAM is uninitialised after power-up, and firmware clears it.

Decomposition:
- Shared package usb_eps_pkg:
  - constants EPS_AW=8, EPS_DW=16
  - host FSM state encoding H_IDLE=2'b00, H_WAIT=2'b01, H_DONE=2'b10
  - tag encoding TAG_NONE/TAG_ENG/TAG_HOST
- Sub-module usb_eps_ram: 256x16 single-port-read/single-port-write RAM wrapper with registered output (write-first). This is the only technology-specific piece.

Test Plan:
- Engine write addr 8'h12 data 16'hA5C3, then eps_read_0 addr 8'h12 two cycles later -> eps_rddata_3=16'hA5C3 exactly 3 cycles after the read.
- Host write 8'h40=16'h1234, then host read 8'h40 -> each host_ack 3 cycles after grant; host_rdata=16'h1234.
- host_req held while the engine issues reads on 5 consecutive cycles -> no grant during those 5 cycles; grant on the 6th, ack 3 cycles later; engine data unaffected.
- Engine write 8'h21=16'hBEEF with eps_zero_0=1 -> subsequent read of 8'h21 returns 16'h0000.
- rst asserted while host in H_WAIT -> no host_ack; host_busy=0 next cycle; a new request then completes normally.
- With USB_EPS_INIT_EN, preload 8'hFF=16'hFFFF, pulse rst -> host_busy high 256 cycles; then read 8'hFF -> 16'h0000.
